bram_instr_loader: RTL and testbench

- Parametrised instruction memory with a sequential program loader and a guarded read port.
- Sits between the host/UART program-load path and the CPU fetch stage.
- Loads a program as a valid/ready stream at auto-incrementing addresses and records the program length.
- Serves fetches with 1-cycle latency; returns FILL_INSTR and flags out-of-bounds for any address outside the loaded program or while not loaded.

---
 rtl/bram_instr_loader.sv | 106 ++++++++++
 tb/tb_bram_instr_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_instr_loader.sv
// Instruction memory with a streaming program loader and a bounds-checked fetch port.
// Loads beats at auto-incrementing addresses; fetches outside the loaded program return FILL_INSTR.
module bram_instr_loader #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 8,
    parameter logic [DATA_W-1:0] FILL_INSTR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_start,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DATA_W-1:0] i_instr_write,
    input  logic              i_wr_last,
    output logic              o_load_done,
    output logic              o_load_overflow,
    output logic [ADDR_W:0]   o_prog_len,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_addr_read,
    output logic [DATA_W-1:0] o_instr_read,
    output logic              o_rd_valid,
    output logic              o_rd_oob
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_accept;
    logic              ptr_at_end;
    logic              rd_in_range;

    assign o_wr_ready  = (state == LOAD) && !i_load_start;
    assign wr_accept   = i_wr_valid && o_wr_ready;
    assign ptr_at_end  = (wr_ptr == {ADDR_W{1'b1}});
    assign rd_in_range = (state == READY) && ({1'b0, i_addr_read} < o_prog_len);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (i_load_start) next_state = LOAD;
            LOAD: begin
                if (i_load_start)
                    next_state = LOAD;
                else if (wr_accept && (i_wr_last || ptr_at_end))
                    next_state = READY;
            end
            READY: if (i_load_start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            o_prog_len      <= '0;
            o_load_done     <= 1'b0;
            o_load_overflow <= 1'b0;
        end else begin
            state       <= next_state;
            o_load_done <= (next_state == READY);
            if (i_load_start) begin
                wr_ptr          <= '0;
                o_prog_len      <= '0;
                o_load_overflow <= 1'b0;
            end else if (wr_accept) begin
                wr_ptr     <= wr_ptr + 1'b1;
                o_prog_len <= o_prog_len + 1'b1;
                if (ptr_at_end && !i_wr_last)
                    o_load_overflow <= 1'b1;
            end
        end
    end

    // NOTE: the array has no reset so it can map onto block RAM; o_prog_len alone defines valid contents.
    always_ff @(posedge i_clk) begin
        if (wr_accept)
            mem[wr_ptr] <= i_instr_write;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_instr_read <= '0;
            o_rd_valid   <= 1'b0;
            o_rd_oob     <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                if (rd_in_range) begin
                    o_instr_read <= mem[i_addr_read];
                    o_rd_oob     <= 1'b0;
                end else begin
                    o_instr_read <= FILL_INSTR;
                    o_rd_oob     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_instr_loader.sv
// Self-checking bench for bram_instr_loader: directed scenarios plus a randomized phase,
// compared every cycle against a list-of-words program model.
module tb_bram_instr_loader;

    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 2 ** ADDR_W;
    localparam logic [15:0] FILL   = 16'h0000;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_load_start = 1'b0;
    logic              i_wr_valid = 1'b0;
    logic              o_wr_ready;
    logic [DATA_W-1:0] i_instr_write = '0;
    logic              i_wr_last = 1'b0;
    logic              o_load_done;
    logic              o_load_overflow;
    logic [ADDR_W:0]   o_prog_len;
    logic              i_rd_en = 1'b0;
    logic [ADDR_W-1:0] i_addr_read = '0;
    logic [DATA_W-1:0] o_instr_read;
    logic              o_rd_valid;
    logic              o_rd_oob;

    int vectors     = 0;
    int miscompares = 0;

    bram_instr_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FILL_INSTR(FILL)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_load_start   (i_load_start),
        .i_wr_valid     (i_wr_valid),
        .o_wr_ready     (o_wr_ready),
        .i_instr_write  (i_instr_write),
        .i_wr_last      (i_wr_last),
        .o_load_done    (o_load_done),
        .o_load_overflow(o_load_overflow),
        .o_prog_len     (o_prog_len),
        .i_rd_en        (i_rd_en),
        .i_addr_read    (i_addr_read),
        .o_instr_read   (o_instr_read),
        .o_rd_valid     (o_rd_valid),
        .o_rd_oob       (o_rd_oob)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Program model: a list of loaded words plus "loading"/"loaded" flags.
    logic [15:0] m_prog [DEPTH];
    int          m_len      = 0;
    bit          m_loading  = 0;
    bit          m_loaded   = 0;
    bit          m_overflow = 0;
    logic [15:0] e_instr    = '0;
    bit          e_valid    = 0;
    bit          e_oob      = 0;

    initial forever begin
        @(posedge i_clk or posedge i_rst);
        if (i_rst) begin
            m_len = 0; m_loading = 0; m_loaded = 0; m_overflow = 0;
            e_instr = '0; e_valid = 0; e_oob = 0;
        end else begin
            e_valid = i_rd_en;
            if (i_rd_en) begin
                if (m_loaded && int'(i_addr_read) < m_len) begin
                    e_instr = m_prog[i_addr_read];
                    e_oob   = 0;
                end else begin
                    e_instr = FILL;
                    e_oob   = 1;
                end
            end
            if (i_load_start) begin
                m_len = 0; m_overflow = 0; m_loading = 1; m_loaded = 0;
            end else if (m_loading && i_wr_valid) begin
                m_prog[m_len] = i_instr_write;
                m_len++;
                if (i_wr_last || m_len == DEPTH) begin
                    m_loading  = 0;
                    m_loaded   = 1;
                    m_overflow = !i_wr_last;
                end
            end
        end
    end

    initial forever begin
        @(negedge i_clk);
        if (!i_rst) begin
            check("wr_ready",  32'(o_wr_ready),      32'(m_loading && !i_load_start));
            check("load_done", 32'(o_load_done),     32'(m_loaded));
            check("overflow",  32'(o_load_overflow), 32'(m_overflow));
            check("prog_len",  32'(o_prog_len),      32'(m_len));
            check("rd_valid",  32'(o_rd_valid),      32'(e_valid));
            check("rd_oob",    32'(o_rd_oob),        32'(e_oob));
            check("instr",     32'(o_instr_read),    32'(e_instr));
        end
    end

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    logic [15:0] wdata [DEPTH];

    task automatic load_words(input int n, input bit with_last, input bit gapped);
        i_load_start = 1'b1;
        cycle();
        i_load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gapped) begin
                i_wr_valid = 1'b0;
                cycle();
            end
            i_wr_valid    = 1'b1;
            i_instr_write = wdata[i];
            i_wr_last     = with_last && (i == n - 1);
            cycle();
        end
        i_wr_valid = 1'b0;
        i_wr_last  = 1'b0;
    endtask

    task automatic read_lit(input logic [7:0] addr, input logic [15:0] exp_data, input bit exp_oob);
        i_rd_en     = 1'b1;
        i_addr_read = addr;
        cycle();
        i_rd_en = 1'b0;
        check("lit_rd_valid", 32'(o_rd_valid), 32'd1);
        check("lit_rd_oob",   32'(o_rd_oob),   32'(exp_oob));
        check("lit_instr",    32'(o_instr_read), 32'(exp_data));
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // Reset state and a read before any program is loaded.
        check("rst_load_done", 32'(o_load_done), 32'd0);
        check("rst_wr_ready",  32'(o_wr_ready),  32'd0);
        read_lit(8'h00, FILL, 1'b1);

        // Three-word program with gapped valid.
        wdata[0] = 16'h1111; wdata[1] = 16'h2222; wdata[2] = 16'h3333;
        load_words(3, 1'b1, 1'b1);
        check("p3_len",  32'(o_prog_len),  32'd3);
        check("p3_done", 32'(o_load_done), 32'd1);
        read_lit(8'h00, 16'h1111, 1'b0);
        read_lit(8'h01, 16'h2222, 1'b0);
        read_lit(8'h02, 16'h3333, 1'b0);
        read_lit(8'h03, FILL, 1'b1);

        // Full-depth load without a last beat.
        for (int i = 0; i < DEPTH; i++) wdata[i] = 16'($urandom);
        load_words(DEPTH, 1'b0, 1'b0);
        check("ovf_len",   32'(o_prog_len),      32'd256);
        check("ovf_flag",  32'(o_load_overflow), 32'd1);
        check("ovf_ready", 32'(o_wr_ready),      32'd0);
        check("ovf_done",  32'(o_load_done),     32'd1);
        read_lit(8'hFF, wdata[255], 1'b0);

        // Reload shorter program: stale words beyond the new length are out of bounds.
        wdata[0] = 16'h0A0A; wdata[1] = 16'h0B0B; wdata[2] = 16'h0C0C;
        load_words(3, 1'b1, 1'b0);
        wdata[0] = 16'hABCD;
        load_words(1, 1'b1, 1'b0);
        check("rl_len", 32'(o_prog_len),      32'd1);
        check("rl_ovf", 32'(o_load_overflow), 32'd0);
        read_lit(8'h00, 16'hABCD, 1'b0);
        read_lit(8'h01, FILL, 1'b1);

        // Restart colliding with a valid beat: beat must be dropped.
        i_load_start = 1'b1;
        cycle();
        i_load_start  = 1'b0;
        i_wr_valid    = 1'b1;
        i_instr_write = 16'h5555;
        cycle();
        i_load_start  = 1'b1;
        i_instr_write = 16'h6666;
        #1 check("col_ready", 32'(o_wr_ready), 32'd0);
        cycle();
        i_load_start = 1'b0;
        i_wr_valid   = 1'b0;
        check("col_len", 32'(o_prog_len), 32'd0);

        // Asynchronous reset mid-load after two beats.
        wdata[0] = 16'h7777; wdata[1] = 16'h8888;
        load_words(2, 1'b0, 1'b0);
        i_rd_en = 1'b1;
        cycle();
        i_rd_en = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check("ar_len",      32'(o_prog_len),      32'd0);
        check("ar_done",     32'(o_load_done),     32'd0);
        check("ar_ready",    32'(o_wr_ready),      32'd0);
        check("ar_ovf",      32'(o_load_overflow), 32'd0);
        check("ar_rd_valid", 32'(o_rd_valid),      32'd0);
        check("ar_rd_oob",   32'(o_rd_oob),        32'd0);
        check("ar_instr",    32'(o_instr_read),    32'd0);
        cycle();
        i_rst = 1'b0;
        read_lit(8'h00, FILL, 1'b1);

        // Randomized traffic, checked every cycle by the model comparator.
        for (int c = 0; c < 3000; c++) begin
            i_load_start  = ($urandom_range(0, 99) < 3);
            i_wr_valid    = 1'($urandom_range(0, 1));
            i_instr_write = 16'($urandom);
            i_wr_last     = ($urandom_range(0, 15) == 0);
            i_rd_en       = 1'($urandom_range(0, 1));
            i_addr_read   = 8'($urandom_range(0, (m_len + 2 > 255) ? 255 : m_len + 2));
            cycle();
        end
        i_load_start = 1'b0;
        i_wr_valid   = 1'b0;
        i_rd_en      = 1'b0;
        repeat (2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
